// File: rtl/tbcm_pkg.sv
// Shared types and helpers for the tbcm stream demultiplexer.
// The TBCM_STREAM_DEMUX_SELECT_CHECK_EN macro (used in tbcm_stream_demux) relies on
// select_legal() from this package.
package tbcm_pkg;

  // Upper bound on ENTRIES; selects are widened to this before decoding.
  localparam int unsigned MaxEntries = 32;
  localparam int unsigned MaxSelBits = 5;

  typedef enum logic {
    IDLE,
    BUSY
  } demux_state_e;

  function automatic int unsigned select_width(int unsigned entries, bit one_hot);
    if (one_hot) begin
      return entries;
    end
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic logic [MaxEntries-1:0] entry_mask(int unsigned entries);
    logic [MaxEntries-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxEntries; i++) begin
      if (i < entries) begin
        mask[i[MaxSelBits-1:0]] = 1'b1;
      end
    end
    return mask;
  endfunction

  // One-hot selects keep only their lowest set bit; binary values beyond the entry count
  // decode to all-zero, which the demux treats as "drop".
  function automatic logic [MaxEntries-1:0] to_one_hot(logic [MaxEntries-1:0] select,
                                                       bit one_hot, int unsigned entries);
    logic [MaxEntries-1:0] masked;
    logic [MaxEntries-1:0] res;
    res = '0;
    if (one_hot) begin
      masked = select & entry_mask(entries);
      res    = masked & (-masked);
    end else begin
      for (int unsigned i = 0; i < MaxEntries; i++) begin
        if ((i < entries) && (select == i)) begin
          res[i[MaxSelBits-1:0]] = 1'b1;
        end
      end
    end
    return res;
  endfunction

  function automatic logic select_legal(logic [MaxEntries-1:0] select, bit one_hot,
                                        int unsigned entries);
    logic [MaxEntries-1:0] mask;
    mask = entry_mask(entries);
    if (one_hot) begin
      return ($countones(select & mask) == 1) && ((select & ~mask) == '0);
    end
    return select < entries;
  endfunction

endpackage

// File: rtl/tbcm_stream_slice.sv
// Single-entry valid/ready register stage with full throughput.
// Ready is combinational from downstream ready so a beat can load while the held one drains.
module tbcm_stream_slice #(
  parameter type payload_t = logic
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_valid,
  output logic     o_ready,
  input  payload_t i_data,
  output logic     o_valid,
  input  logic     i_ready,
  output payload_t o_data
);

  logic     valid_q;
  payload_t data_q;

  assign o_ready = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  // Load on accept; empty when the held beat drains with nothing behind it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (o_ready) begin
        valid_q <= i_valid;
      end
      if (i_valid && o_ready) begin
        data_q <= i_data;
      end
    end
  end

endmodule

// File: rtl/tbcm_stream_demux.sv
// Streaming 1-to-ENTRIES demultiplexer with a registered output stage.
// Destination is taken from i_select on a packet's first beat and held until its last beat.
// Define TBCM_STREAM_DEMUX_SELECT_CHECK_EN to drop packets with an illegal select and raise
// the sticky o_select_error flag; otherwise illegal one-hot selects use their lowest set bit.
module tbcm_stream_demux
  import tbcm_pkg::*;
#(
  parameter int unsigned WIDTH        = 2,
  parameter type         DATA_TYPE    = logic [WIDTH-1:0],
  parameter int unsigned ENTRIES      = 2,
  parameter bit          ONE_HOT      = 1'b1,
  localparam int unsigned SELECT_WIDTH = select_width(ENTRIES, ONE_HOT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  DATA_TYPE                i_data,
  input  logic                    i_last,
  output logic [ENTRIES-1:0]      o_valid,
  input  logic [ENTRIES-1:0]      i_ready,
  output DATA_TYPE                o_data,
  output logic                    o_last,
  output logic                    o_select_error
);

  typedef struct packed {
    logic [ENTRIES-1:0] dest;
    logic               last;
    DATA_TYPE           data;
  } payload_t;

  demux_state_e          state_q;
  logic [ENTRIES-1:0]    dest_q;
  logic [MaxEntries-1:0] sel_wide;
  logic [MaxEntries-1:0] sel_hot;
  logic [ENTRIES-1:0]    first_dest;
  logic [ENTRIES-1:0]    beat_dest;
  logic                  drop;
  logic                  accept;
  logic                  slice_valid;
  logic                  slice_ready;
  logic                  stage_valid;
  logic                  stage_ready;
  logic                  unused_sel_hot;
  payload_t              in_pl;
  payload_t              out_pl;
`ifdef TBCM_STREAM_DEMUX_SELECT_CHECK_EN
  logic                  sel_legal;
  logic                  sel_err_q;
`endif

  assign unused_sel_hot = ^sel_hot;

  // Decode the select; an all-zero destination means the packet is swallowed.
  always_comb begin
    sel_wide                     = '0;
    sel_wide[SELECT_WIDTH-1:0]   = i_select;
    sel_hot                      = to_one_hot(sel_wide, ONE_HOT, ENTRIES);
`ifdef TBCM_STREAM_DEMUX_SELECT_CHECK_EN
    sel_legal                    = select_legal(sel_wide, ONE_HOT, ENTRIES);
    first_dest                   = sel_legal ? sel_hot[ENTRIES-1:0] : '0;
`else
    first_dest                   = sel_hot[ENTRIES-1:0];
`endif
    beat_dest                    = (state_q == BUSY) ? dest_q : first_dest;
    drop                         = (beat_dest == '0);
    o_ready                      = drop || slice_ready;
    accept                       = i_valid && o_ready;
    slice_valid                  = i_valid && !drop;
    in_pl.dest                   = beat_dest;
    in_pl.last                   = i_last;
    in_pl.data                   = i_data;
  end

  tbcm_stream_slice #(
    .payload_t(payload_t)
  ) u_slice (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(slice_valid),
    .o_ready(slice_ready),
    .i_data (in_pl),
    .o_valid(stage_valid),
    .i_ready(stage_ready),
    .o_data (out_pl)
  );

  // Only the ready of the held beat's destination can drain the stage.
  always_comb begin
    stage_ready = |(i_ready & out_pl.dest);
    o_valid     = {ENTRIES{stage_valid}} & out_pl.dest;
    o_data      = out_pl.data;
    o_last      = out_pl.last;
  end

  // Packet-tracking FSM: lock the destination after a first beat that is not also last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (!i_last) begin
            state_q <= BUSY;
            dest_q  <= first_dest;
          end
        end
        BUSY: begin
          if (i_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TBCM_STREAM_DEMUX_SELECT_CHECK_EN
  // Sticky flag set by any accepted first beat carrying an illegal select.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && (state_q == IDLE) && !sel_legal) begin
      sel_err_q <= 1'b1;
    end
  end

  assign o_select_error = sel_err_q;
`else
  assign o_select_error = 1'b0;
`endif

endmodule

// File: tb/tb_tbcm_stream_demux.sv
// Scoreboard bench: instance 0 is binary-select, instance 1 is one-hot select, both 4 outputs.
module tb_tbcm_stream_demux;

  typedef struct {
    int         dest;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      valid = '0;
  logic [1:0]      last = '0;
  logic [1:0][3:0] sel = '0;
  logic [1:0][7:0] data = '0;
  logic [1:0][3:0] rdy = '1;
  logic [1:0][3:0] rdy_fixed = '1;
  logic            rnd_rdy = 1'b0;

  logic [3:0] ov_b, ov_h;
  logic [7:0] od_b, od_h;
  logic       ol_b, ol_h, ordy_b, ordy_h, oerr_b, oerr_h;

  wire [1:0][3:0] ov   = {ov_h, ov_b};
  wire [1:0][7:0] od   = {od_h, od_b};
  wire [1:0]      ol   = {ol_h, ol_b};
  wire [1:0]      ordy = {ordy_h, ordy_b};
  wire [1:0]      oerr = {oerr_h, oerr_b};

  tbcm_stream_demux #(
    .WIDTH  (8),
    .ENTRIES(4),
    .ONE_HOT(1'b0)
  ) dut_bin (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid[0]),
    .o_ready       (ordy_b),
    .i_select      (sel[0][1:0]),
    .i_data        (data[0]),
    .i_last        (last[0]),
    .o_valid       (ov_b),
    .i_ready       (rdy[0]),
    .o_data        (od_b),
    .o_last        (ol_b),
    .o_select_error(oerr_b)
  );

  tbcm_stream_demux #(
    .WIDTH  (8),
    .ENTRIES(4),
    .ONE_HOT(1'b1)
  ) dut_oh (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid[1]),
    .o_ready       (ordy_h),
    .i_select      (sel[1]),
    .i_data        (data[1]),
    .i_last        (last[1]),
    .o_valid       (ov_h),
    .i_ready       (rdy[1]),
    .o_data        (od_h),
    .o_last        (ol_h),
    .o_select_error(oerr_h)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t qb[$];
  exp_t qh[$];
  bit   in_pkt[2];
  int   pkt_dest[2];
  bit   err_exp[2];
  bit   occ_pre[2];
  int   dest_pre[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(int inst);
    return (inst == 0) ? qb.size() : qh.size();
  endfunction

  function automatic exp_t q_front(int inst);
    return (inst == 0) ? qb[0] : qh[0];
  endfunction

  task automatic q_pop(int inst);
    exp_t e;
    if (inst == 0) e = qb.pop_front();
    else e = qh.pop_front();
  endtask

  task automatic q_push(int inst, exp_t e);
    if (inst == 0) qb.push_back(e);
    else qh.push_back(e);
  endtask

  // Destination index chosen for a first beat, or -1 when the packet is dropped.
  function automatic int ref_dest(int inst, logic [3:0] s);
    logic [1:0] v;
    if (inst == 0) begin
      v = s[1:0];
      return int'(v);
    end
    if ($countones(s) == 1) begin
      for (int k = 0; k < 4; k++) if (s[k]) return k;
    end
`ifdef TBCM_STREAM_DEMUX_SELECT_CHECK_EN
    return -1;
`else
    for (int k = 0; k < 4; k++) if (s[k]) return k;
    return -1;
`endif
  endfunction

  // Ready pattern: either held by the test or re-rolled every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) rdy[i] = rnd_rdy ? 4'($urandom) : rdy_fixed[i];
    end
  end

  // Output monitor: whatever sits in the stage must be the oldest expected beat.
  initial begin
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        for (int i = 0; i < 2; i++) begin
          occ_pre[i] = (q_size(i) > 0);
          if (occ_pre[i]) begin
            e           = q_front(i);
            dest_pre[i] = e.dest;
            oh          = 4'b0001 << e.dest;
            chk($sformatf("o_valid[%0d]", i), 32'(ov[i]), 32'(oh));
            chk($sformatf("o_data[%0d]", i), 32'(od[i]), 32'(e.data));
            chk($sformatf("o_last[%0d]", i), 32'(ol[i]), 32'(e.last));
            if (rdy[i][e.dest]) q_pop(i);
          end else begin
            chk($sformatf("o_valid_idle[%0d]", i), 32'(ov[i]), 32'h0);
          end
          chk($sformatf("o_select_error[%0d]", i), 32'(oerr[i]), 32'(err_exp[i]));
        end
      end
    end
  end

  // Offer one beat, wait for acceptance and record the expected outcome.
  task automatic send(int inst, logic [3:0] s, logic [7:0] d, logic l);
    bit   done;
    bit   exp_rdy;
    int   dst;
    int   budget;
    exp_t e;
    valid[inst] = 1'b1;
    sel[inst]   = s;
    data[inst]  = d;
    last[inst]  = l;
    done        = 1'b0;
    budget      = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      dst     = in_pkt[inst] ? pkt_dest[inst] : ref_dest(inst, s);
      exp_rdy = (dst < 0) || !occ_pre[inst] || rdy[inst][dest_pre[inst]];
      chk($sformatf("o_ready[%0d]", inst), 32'(ordy[inst]), 32'(exp_rdy));
      if (ordy[inst]) begin
        if (dst >= 0) begin
          e.dest = dst;
          e.data = d;
          e.last = l;
          q_push(inst, e);
        end
`ifdef TBCM_STREAM_DEMUX_SELECT_CHECK_EN
        if (!in_pkt[inst] && (inst == 1) && ($countones(s) != 1)) err_exp[inst] = 1'b1;
`endif
        if (!in_pkt[inst]) begin
          if (!l) begin
            in_pkt[inst]   = 1'b1;
            pkt_dest[inst] = dst;
          end
        end else if (l) begin
          in_pkt[inst] = 1'b0;
        end
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 50) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_timeout[%0d]: no acceptance within 50 cycles", inst);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    valid[inst] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    qb.delete();
    qh.delete();
    for (int i = 0; i < 2; i++) begin
      in_pkt[i]  = 1'b0;
      pkt_dest[i] = 0;
      err_exp[i] = 1'b0;
      occ_pre[i] = 1'b0;
      dest_pre[i] = 0;
    end
  endtask

  initial begin
    int         len;
    logic [3:0] s;
    model_reset();
    // Reset hold
    repeat (3) @(posedge clk);
    #3;
    chk("rst_o_valid_b", 32'(ov_b), 32'h0);
    chk("rst_o_valid_h", 32'(ov_h), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_o_ready_b", 32'(ordy_b), 32'h1);
    chk("post_rst_o_ready_h", 32'(ordy_h), 32'h1);
    chk("post_rst_err_h", 32'(oerr_h), 32'h0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Back-to-back single-beat packets on the binary instance
    send(0, 4'd2, 8'h11, 1'b1);
    send(0, 4'd0, 8'h22, 1'b1);
    send(0, 4'd3, 8'h33, 1'b1);
    idle(2);

    // Destination locked for the whole packet, then a fresh first beat
    send(0, 4'd1, 8'h41, 1'b0);
    send(0, 4'd3, 8'h42, 1'b0);
    send(0, 4'd3, 8'h43, 1'b1);
    send(0, 4'd2, 8'h44, 1'b1);
    idle(2);

    // Destination stall mid-packet; other outputs' ready must not matter
    send(0, 4'd1, 8'h51, 1'b0);
    rdy_fixed[0] = 4'b1101;
    fork
      begin
        send(0, 4'd3, 8'h52, 1'b0);
        send(0, 4'd3, 8'h53, 1'b0);
        send(0, 4'd0, 8'h54, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        rdy_fixed[0] = 4'hF;
      end
    join
    idle(2);

    // One-hot instance: multi-bit select, then zero select, then a legal packet
    send(1, 4'b0110, 8'h61, 1'b0);
    send(1, 4'b0001, 8'h62, 1'b1);
    idle(2);
`ifdef TBCM_STREAM_DEMUX_SELECT_CHECK_EN
    chk("select_error_set", 32'(oerr_h), 32'h1);
`else
    chk("select_error_tied", 32'(oerr_h), 32'h0);
`endif
    send(1, 4'b0000, 8'h63, 1'b1);
    send(1, 4'b1000, 8'h64, 1'b1);
    idle(2);

    // Asynchronous reset while busy with a full stage
    rdy_fixed[0] = 4'h0;
    send(0, 4'd2, 8'h71, 1'b0);
    #3;
    rst_n = 1'b0;
    #2;
    chk("async_rst_o_valid", 32'(ov_b), 32'h0);
    model_reset();
    idle(2);
    #2;
    rst_n = 1'b1;
    rdy_fixed[0] = 4'hF;
    idle(1);
    send(0, 4'd0, 8'h72, 1'b1);
    idle(2);

    // Randomized packets with random downstream ready
    rnd_rdy = 1'b1;
    for (int inst = 0; inst < 2; inst++) begin
      for (int p = 0; p < 40; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          s = 4'($urandom);
          if (inst == 0) s[3:2] = 2'b00;
          else if (b == 0 && $urandom_range(0, 3) != 0) s = 4'b0001 << $urandom_range(0, 3);
          send(inst, s, 8'($urandom), (b == len - 1));
        end
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end
    rnd_rdy = 1'b0;
    rdy_fixed = '1;
    idle(6);
    chk("drain_b", 32'(qb.size()), 32'h0);
    chk("drain_h", 32'(qh.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
